// File: rtl/project_types.sv
// Shared pipeline types: reset polarity, ALU op encodings, write-back/HI-LO records
// and the MEM-stage RAM bus and FSM state types.
package project_types;

   typedef logic reset_status_t;
   localparam reset_status_t RST_ENABLE = 1'b1;

   typedef enum logic [7:0] {
      NOP_OP = 8'h00,
      ADD_OP = 8'h20,
      LB_OP  = 8'h80,
      LW_OP  = 8'h83,
      SB_OP  = 8'h88,
      SW_OP  = 8'h8B
   } alu_op_t;

   typedef logic [2:0]  alu_sel_t;
   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] reg_data_t;
   typedef logic [31:0] ram_addr_t;
   typedef logic [3:0]  ram_sel_t;

   typedef struct packed {
      alu_op_t  op;
      alu_sel_t sel;
   } alu_t;

   typedef struct packed {
      logic      en;
      reg_addr_t addr;
      reg_data_t data;
   } reg_t;

   typedef struct packed {
      logic      en;
      reg_data_t hi;
      reg_data_t lo;
   } hilo_t;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_BUSY = 2'd1,
      MEM_DONE = 2'd2
   } mem_state_t;

   typedef struct packed {
      logic      req;
      logic      we;
      ram_addr_t addr;
      ram_sel_t  sel;
      reg_data_t wdata;
   } ram_bus_t;

   function automatic logic is_load(input alu_op_t op);
      return (op == LB_OP) || (op == LW_OP);
   endfunction

   function automatic logic is_store(input alu_op_t op);
      return (op == SB_OP) || (op == SW_OP);
   endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for loads and stores: byte enables, store data replication,
// sign-extended byte extraction and word-misalignment detection.
import project_types::*;

module mem_align (
   input  alu_op_t   op,
   input  logic [1:0] lane,
   input  reg_data_t sdata,
   input  reg_data_t rdata,
   output ram_sel_t  sel,
   output reg_data_t wdata,
   output reg_data_t ld_data,
   output logic      misalign
);

   logic       byte_op;
   logic [7:0] ld_byte;

   assign byte_op  = (op == LB_OP) || (op == SB_OP);
   assign misalign = ((op == LW_OP) || (op == SW_OP)) && (lane != 2'b00);
   assign ld_byte  = rdata[{lane, 3'b000} +: 8];

   always_comb begin
      sel     = 4'b1111;
      wdata   = sdata;
      ld_data = rdata;
      if (byte_op) begin
         sel = 4'b0001 << lane;
      end
      if (op == SB_OP) begin
         wdata = {4{sdata[7:0]}};
      end
      if (op == LB_OP) begin
         ld_data = {{24{ld_byte[7]}}, ld_byte};
      end
   end

endmodule

// File: rtl/mem_access.sv
// Pipeline MEM stage: runs LB/LW/SB/SW over a req/ack RAM bus, stalling the
// pipeline until the access completes, and forms the MEM/WB write-back record.
import project_types::*;

module mem_access (
   input  logic          clk,
   input  reset_status_t rst,
   input  alu_t          mem_alu_i,
   input  reg_t          mem_wreg_i,
   input  hilo_t         mem_hilo_i,
   input  ram_addr_t     mem_ramaddr_i,
   input  reg_data_t     mem_storedata_i,
   output reg_t          mem_wreg_o,
   output hilo_t         mem_hilo_o,
   output logic          stallreq_from_mem,
   output logic          mem_misalign_o,
   output logic          ram_req_o,
   output logic          ram_we_o,
   output logic [31:0]   ram_addr_o,
   output logic [3:0]    ram_sel_o,
   output logic [31:0]   ram_wdata_o,
   input  logic [31:0]   ram_rdata_i,
   input  logic          ram_ack_i,
   output mem_state_t    state
);

   mem_state_t state_q, state_d;
   ram_bus_t   ram_q, ram_d;
   reg_data_t  ld_data_q, ld_data_d;

   ram_sel_t   al_sel;
   reg_data_t  al_wdata;
   reg_data_t  al_ld_data;
   logic       al_misalign;
   logic       mem_op;
   logic       unused_alu_sel;

   assign unused_alu_sel = ^mem_alu_i.sel;

   mem_align u_align (
      .op       (mem_alu_i.op),
      .lane     (mem_ramaddr_i[1:0]),
      .sdata    (mem_storedata_i),
      .rdata    (ram_rdata_i),
      .sel      (al_sel),
      .wdata    (al_wdata),
      .ld_data  (al_ld_data),
      .misalign (al_misalign)
   );

   assign mem_op = (is_load(mem_alu_i.op) || is_store(mem_alu_i.op)) && !al_misalign;

   // Bus fields are latched once in IDLE and held untouched through BUSY;
   // the pipeline is stalled, so op/addr are still valid when the ack arrives.
   always_comb begin
      state_d   = state_q;
      ram_d     = ram_q;
      ld_data_d = ld_data_q;
      unique case (state_q)
         MEM_IDLE: begin
            if (mem_op) begin
               state_d     = MEM_BUSY;
               ram_d.req   = 1'b1;
               ram_d.we    = is_store(mem_alu_i.op);
               ram_d.addr  = {mem_ramaddr_i[31:2], 2'b00};
               ram_d.sel   = al_sel;
               ram_d.wdata = al_wdata;
            end
         end
         MEM_BUSY: begin
            if (ram_ack_i) begin
               state_d   = MEM_DONE;
               ram_d.req = 1'b0;
               ld_data_d = al_ld_data;
            end
         end
         MEM_DONE: state_d = MEM_IDLE;
         default:  state_d = MEM_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q   <= MEM_IDLE;
         ram_q     <= '0;
         ld_data_q <= '0;
      end else begin
         state_q   <= state_d;
         ram_q     <= ram_d;
         ld_data_q <= ld_data_d;
      end
   end

   always_comb begin
      mem_wreg_o        = mem_wreg_i;
      mem_hilo_o        = mem_hilo_i;
      stallreq_from_mem = 1'b0;
      mem_misalign_o    = 1'b0;
      if (rst == RST_ENABLE) begin
         mem_wreg_o = '0;
         mem_hilo_o = '0;
      end else begin
         mem_misalign_o    = al_misalign;
         stallreq_from_mem = mem_op && (state_q != MEM_DONE);
         if (al_misalign) begin
            mem_wreg_o.en = 1'b0;
         end else if (is_load(mem_alu_i.op)) begin
            mem_wreg_o.data = (state_q == MEM_DONE) ? ld_data_q : '0;
         end else if (is_store(mem_alu_i.op)) begin
            mem_wreg_o.en = 1'b0;
         end
      end
   end

   assign state       = state_q;
   assign ram_req_o   = ram_q.req;
   assign ram_we_o    = ram_q.we;
   assign ram_addr_o  = ram_q.addr;
   assign ram_sel_o   = ram_q.sel;
   assign ram_wdata_o = ram_q.wdata;

endmodule
